// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: ControlBus bit map, FSM encoding and port indices shared by the
// arbiter, the CPU and DataMemory.
package mem_bus_pkg;

    localparam int CB_W         = 3;
    localparam int CB_WRITE_BIT = 2;
    localparam int CB_READ_BIT  = 1;
    localparam int CB_RSVD_BIT  = 0;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-port winner select. A lone requester always wins; a tie goes
// to port 0 in fixed-priority mode, otherwise to the port not granted last.
module rr_arb2
    import mem_bus_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       any_o,
    output logic       win_o
);

    // Pure combinational pick; the caller decides when to act on it.
    always_comb begin
        any_o = |req_i;
        win_o = 1'(PORT_CPU);
        if (req_i == 2'b10) begin
            win_o = 1'(PORT_AUX);
        end else if (req_i == 2'b11) begin
            win_o = (PRIO_MODE == 1) ? 1'(PORT_CPU) : ~last_grant_i;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single DataMemory port between the CPU data port
// (port 0) and an auxiliary master (port 1). One transaction in flight at a
// time: arbitrate -> issue -> wait read latency -> return data. All outputs
// are registered; per-port stall counters saturate.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 0,   // 0..7 cycles after the ISSUE edge
    parameter int PRIO_MODE = 0    // 0 round-robin, 1 port 0 always wins
) (
    input  logic              InputClk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] AddressBus,
    output logic [DATA_W-1:0] DataBusOut,
    input  logic [DATA_W-1:0] DataBusIn,
    output logic [CB_W-1:0]   ControlBus,
    output logic [31:0]       stall0,
    output logic [31:0]       stall1
);

    localparam logic [2:0] LAT = 3'(RD_LAT);

    mb_state_e         state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [CB_W-1:0]   cb_q, cb_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       stall0_q, stall0_d;
    logic [31:0]       stall1_q, stall1_d;

    logic              arb_any;
    logic              arb_win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
        .req_i       (req),
        .last_grant_i(last_grant_q),
        .any_o       (arb_any),
        .win_o       (arb_win)
    );

    assign win_we    = we[arb_win];
    assign win_addr  = arb_win ? addr1 : addr0;
    assign win_wdata = arb_win ? wdata1 : wdata0;

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        gnt_d        = '0;
        rvalid_d     = '0;
        cb_d         = '0;
        abus_d       = abus_q;
        dout_d       = dout_q;
        rdata_d      = rdata_q;
        // A cycle with req up and no gnt showing counts, busy or not.
        stall0_d = (req[PORT_CPU] && !gnt_q[PORT_CPU]) ? sat_inc32(stall0_q) : stall0_q;
        stall1_d = (req[PORT_AUX] && !gnt_q[PORT_AUX]) ? sat_inc32(stall1_q) : stall1_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    last_grant_d          = arb_win;
                    we_d                  = win_we;
                    abus_d                = win_addr;
                    if (win_we) dout_d    = win_wdata;  // reads leave DataBusOut alone
                    gnt_d[arb_win]        = 1'b1;
                    cb_d[CB_WRITE_BIT]    = win_we;
                    cb_d[CB_READ_BIT]     = ~win_we;
                    cb_d[CB_RSVD_BIT]     = 1'b0;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (LAT == 3'd0) begin
                    rdata_d                = DataBusIn;
                    rvalid_d[last_grant_q] = 1'b1;
                    state_d                = RESP;
                end else begin
                    lat_d   = 3'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == LAT) begin
                    rdata_d                = DataBusIn;
                    rvalid_d[last_grant_q] = 1'b1;
                    state_d                = RESP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            last_grant_q <= 1'(PORT_AUX);  // so port 0 wins the first tie
            we_q         <= 1'b0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            cb_q         <= '0;
            abus_q       <= '0;
            dout_q       <= '0;
            rdata_q      <= '0;
            stall0_q     <= '0;
            stall1_q     <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            cb_q         <= cb_d;
            abus_q       <= abus_d;
            dout_q       <= dout_d;
            rdata_q      <= rdata_d;
            stall0_q     <= stall0_d;
            stall1_q     <= stall1_d;
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign AddressBus = abus_q;
    assign DataBusOut = dout_q;
    assign ControlBus = cb_q;
    assign stall0     = stall0_q;
    assign stall1     = stall1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. Three instances share one stimulus stream:
//   [0] RD_LAT=0 round-robin, [1] RD_LAT=0 fixed priority, [2] RD_LAT=3 round-robin.
// Each instance has its own small memory whose DataBusIn is only valid in the
// cycle the read latency says it should be.
module tb_mem_bus_arbiter;

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] PL = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic [1:0]  gnt_w [3];
    logic [1:0]  rv_w  [3];
    logic [31:0] rd_w  [3];
    logic [31:0] ab_w  [3];
    logic [31:0] dbo_w [3];
    logic [31:0] dbi_w [3];
    logic [2:0]  cb_w  [3];
    logic [31:0] s0_w  [3];
    logic [31:0] s1_w  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 0;
        localparam int PRI = (g == 1) ? 1 : 0;
        logic [31:0] mem [256];
        logic [2:0]  age;

        mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .PRIO_MODE(PRI)) u_dut (
            .InputClk(clk), .rst(rst), .req(req), .we(we),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .gnt(gnt_w[g]), .rvalid(rv_w[g]), .rdata(rd_w[g]),
            .AddressBus(ab_w[g]), .DataBusOut(dbo_w[g]), .DataBusIn(dbi_w[g]),
            .ControlBus(cb_w[g]), .stall0(s0_w[g]), .stall1(s1_w[g]));

        // Memory model: writes on MemWriteEn, age counts cycles since MemReadEn.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                age        <= '0;
                mem[8'h20] <= PL;
            end else begin
                if (cb_w[g][2]) mem[ab_w[g][7:0]] <= dbo_w[g];
                if (cb_w[g][1]) age <= 3'd1;
                else if (age != 3'd0 && age != 3'd7) age <= age + 3'd1;
            end
        end

        assign dbi_w[g] = ((LAT == 0) ? cb_w[g][1] : (age == 3'(LAT)))
                          ? mem[ab_w[g][7:0]] : 32'hBAD0_BAD0;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rs;
        logic [1:0]  req, we;
        logic [31:0] a0, a1, d0;
        logic [1:0]  gnt, rv;
        logic [2:0]  cb;
        logic [31:0] ab, rd, dbo, s0, s1;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic [1:0] rq, input logic [1:0] w,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                                input logic [1:0] g, input logic [1:0] rv, input logic [2:0] cb,
                                input logic [31:0] ab, input logic [31:0] rd, input logic [31:0] dbo,
                                input logic [31:0] s0, input logic [31:0] s1);
        vec_t v;
        v.rs = rs; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0;
        v.gnt = g; v.rv = rv; v.cb = cb; v.ab = ab; v.rd = rd; v.dbo = dbo; v.s0 = s0; v.s1 = s1;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Port 0: write 0x10, then read it back.
        //                 rs  req    we     a0     a1     d0     gnt    rv     cb      ab     rd  dbo s0  s1
        tbl.push_back(mk(1, 2'b01, 2'b01, 32'h10, 32'h0, DB,    2'b01, 2'b00, 3'b100, 32'h10, 0,  DB, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 32'h10, 32'h0, DB,    2'b00, 2'b00, 3'b000, 32'h10, 0,  DB, 1, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 2'b01, 2'b00, 3'b010, 32'h10, 0,  DB, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 2'b00, 2'b01, 3'b000, 32'h10, DB, DB, 2, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 2'b00, 2'b00, 3'b000, 32'h10, DB, DB, 2, 0));
        // Both ports read continuously, round-robin: 0,1,0,1.
        tbl.push_back(mk(1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b01, 2'b00, 3'b010, 32'h10, 0,  0, 1,  1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b01, 3'b000, 32'h10, DB, 0, 1,  2));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 3'b000, 32'h10, DB, 0, 2,  3));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b10, 2'b00, 3'b010, 32'h20, DB, 0, 3,  4));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b10, 3'b000, 32'h20, PL, 0, 4,  4));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 3'b000, 32'h20, PL, 0, 5,  5));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b01, 2'b00, 3'b010, 32'h10, PL, 0, 6,  6));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b01, 3'b000, 32'h10, DB, 0, 6,  7));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 3'b000, 32'h10, DB, 0, 7,  8));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b10, 2'b00, 3'b010, 32'h20, DB, 0, 8,  9));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b10, 3'b000, 32'h20, PL, 0, 9,  9));
        tbl.push_back(mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 2'b00, 2'b00, 3'b000, 32'h20, PL, 0, 10, 10));

        // Reset state, all outputs zero.
        rst = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        chk("rst gnt",    32'(gnt_w[0]), 0);
        chk("rst rvalid", 32'(rv_w[0]),  0);
        chk("rst cb",     32'(cb_w[0]),  0);
        chk("rst ab",     ab_w[0],       0);
        chk("rst dbo",    dbo_w[0],      0);
        chk("rst rdata",  rd_w[0],       0);
        chk("rst stall0", s0_w[0],       0);
        chk("rst stall1", s1_w[0],       0);
        chk("rst cb i1",  32'(cb_w[1]),  0);
        chk("rst cb i2",  32'(cb_w[2]),  0);

        // Table vectors on instance 0.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            req = tbl[i].req; we = tbl[i].we;
            addr0 = tbl[i].a0; addr1 = tbl[i].a1; wdata0 = tbl[i].d0; wdata1 = '0;
            step();
            chk($sformatf("vec%0d gnt", i),    32'(gnt_w[0]), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d rvalid", i), 32'(rv_w[0]),  32'(tbl[i].rv));
            chk($sformatf("vec%0d cb", i),     32'(cb_w[0]),  32'(tbl[i].cb));
            chk($sformatf("vec%0d ab", i),     ab_w[0],       tbl[i].ab);
            chk($sformatf("vec%0d rdata", i),  rd_w[0],       tbl[i].rd);
            chk($sformatf("vec%0d dbo", i),    dbo_w[0],      tbl[i].dbo);
            chk($sformatf("vec%0d stall0", i), s0_w[0],       tbl[i].s0);
            chk($sformatf("vec%0d stall1", i), s1_w[0],       tbl[i].s1);
        end

        // Fixed priority: port 0 wins every tie, port 1 stalls every cycle.
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("prio gnt k%0d", k), 32'(gnt_w[1]), 32'((k % 3 == 0) ? 1 : 0));
            chk($sformatf("prio stall1 k%0d", k), s1_w[1], 32'(k + 1));
        end
        req = 2'b10;
        step();
        chk("prio p1 gnt",    32'(gnt_w[1]), 32'b10);
        chk("prio p1 stall1", s1_w[1],       32'd10);
        req = 2'b00;
        step();
        chk("prio p1 rvalid", 32'(rv_w[1]), 32'b10);
        chk("prio p1 rdata",  rd_w[1],      PL);

        // RD_LAT=3: rvalid 5 cycles after req, read enable for one cycle.
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h20;
        step();
        chk("lat3 gnt", 32'(gnt_w[2]), 32'b01);
        chk("lat3 cb",  32'(cb_w[2]),  32'b010);
        req = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("lat3 cb k%0d", k), 32'(cb_w[2]), 0);
            chk($sformatf("lat3 rvalid k%0d", k), 32'(rv_w[2]), 32'((k == 3) ? 1 : 0));
            if (k == 3) chk("lat3 rdata", rd_w[2], PL);
        end

        // Reset mid-ISSUE clears ControlBus/gnt without a clock edge.
        do_reset();
        req = 2'b10; we = 2'b00; addr1 = 32'h20;
        step();
        chk("arst pre cb",  32'(cb_w[0]),  32'b010);
        chk("arst pre gnt", 32'(gnt_w[0]), 32'b10);
        rst = 1'b0;
        #1;
        chk("arst cb",  32'(cb_w[0]),  0);
        chk("arst gnt", 32'(gnt_w[0]), 0);
        chk("arst ab",  ab_w[0],       0);
        req = 2'b00;
        step();
        rst = 1'b1;
        // Reset during WAIT of a port-1 read, then a tie: port 0 first, no stale rvalid.
        req = 2'b10;
        step();
        chk("wrst p1 gnt", 32'(gnt_w[2]), 32'b10);
        req = 2'b00;
        step();
        rst = 1'b0;
        #1;
        chk("wrst cb",     32'(cb_w[2]),  0);
        chk("wrst gnt",    32'(gnt_w[2]), 0);
        chk("wrst rvalid", 32'(rv_w[2]),  0);
        step();
        rst = 1'b1;
        req = 2'b11; addr0 = 32'h20; addr1 = 32'h30;
        step();
        chk("wrst tie gnt", 32'(gnt_w[2]), 32'b01);
        req = 2'b00;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("wrst rvalid k%0d", k), 32'(rv_w[2]), 32'((k == 3) ? 1 : 0));
        end
        chk("wrst rdata", rd_w[2], PL);

        // Port 1 requests only while port 0 is busy, then drops: never served.
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 32'h20; addr1 = 32'h50;
        step();
        chk("drop p0 gnt", 32'(gnt_w[0]), 32'b01);
        req = 2'b10;
        step();
        chk("drop gnt a",    32'(gnt_w[0]), 0);
        chk("drop cb a",     32'(cb_w[0]),  0);
        chk("drop p0 rvalid", 32'(rv_w[0]), 32'b01);
        step();
        chk("drop gnt b", 32'(gnt_w[0]), 0);
        chk("drop cb b",  32'(cb_w[0]),  0);
        req = 2'b00;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("drop gnt k%0d", k), 32'(gnt_w[0]), 0);
            chk($sformatf("drop cb k%0d", k),  32'(cb_w[0]),  0);
        end
        chk("drop stall1", s1_w[0], 32'd2);
        // Port 1 write then read-back.
        req = 2'b10; we = 2'b10; addr1 = 32'h30; wdata1 = 32'h55AA_55AA;
        step();
        chk("p1 wr gnt", 32'(gnt_w[0]), 32'b10);
        chk("p1 wr cb",  32'(cb_w[0]),  32'b100);
        chk("p1 wr ab",  ab_w[0],       32'h30);
        chk("p1 wr dbo", dbo_w[0],      32'h55AA_55AA);
        req = 2'b00; we = 2'b00;
        step();
        req = 2'b10;
        step();
        chk("p1 rd gnt", 32'(gnt_w[0]), 32'b10);
        chk("p1 rd cb",  32'(cb_w[0]),  32'b010);
        req = 2'b00;
        step();
        chk("p1 rd rvalid", 32'(rv_w[0]), 32'b10);
        chk("p1 rd rdata",  rd_w[0],      32'h55AA_55AA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
